// File: rtl/int_ctrl_pkg.sv
// Shared constants for the prioritised interrupt controller: register word
// addresses and the width of the interrupt vector index.
package int_ctrl_pkg;

   localparam int VEC_W = 5;

   localparam logic [2:0] ADDR_MER = 3'd0;
   localparam logic [2:0] ADDR_IER = 3'd1;
   localparam logic [2:0] ADDR_IAR = 3'd2;
   localparam logic [2:0] ADDR_IPR = 3'd3;
   localparam logic [2:0] ADDR_IMR = 3'd4;
   localparam logic [2:0] ADDR_IVR = 3'd5;

endpackage

// File: rtl/prio_int_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit and whether
// any request is set.
module prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]     req_i,
   output logic [VEC_W-1:0] idx_o,
   output logic             valid_o
);

   // Scanning from the top down lets the lowest set bit overwrite the rest.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = VEC_W'(i);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/prio_int_ctrl.sv
// Prioritised interrupt controller with a two-cycle register slave port.
// Define PRIO_INT_CTRL_SYNC_EN to put a 2-flop synchroniser on int_i.
module prio_int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int INT_NUM    = 8,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sa_dat_i,
   input  logic [SEL_WIDTH-1:0]  sa_sel_i,
   input  logic [ADDR_WIDTH-1:0] sa_addr_i,
   input  logic                  sa_stb_i,
   input  logic                  sa_we_i,
   output logic [DATA_WIDTH-1:0] sa_dat_o,
   output logic                  sa_ack_o,
   input  logic [INT_NUM-1:0]    int_i,
   output logic                  int_o,
   output logic [VEC_W-1:0]      int_vec_o
);

   logic                  access, wrEn;
   logic                  selMer, selIer, selIar, selIpr, selImr, selIvr;
   logic [INT_NUM-1:0]    wrData, inSync, active, edgeSet, swSet, swClr, imrChanged;
   logic [VEC_W-1:0]      encIdx;
   logic                  encValid;
   logic                  unusedBits;

   logic [1:0]            mer_q, mer_d;
   logic [INT_NUM-1:0]    ier_q, ier_d;
   logic [INT_NUM-1:0]    imr_q, imr_d;
   logic [INT_NUM-1:0]    pending_q, pending_d;
   logic [INT_NUM-1:0]    prevIn_q;
   logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
   logic                  ack_q;
   logic                  intOut_q, intOut_d;
   logic [VEC_W-1:0]      vec_q;

   assign unusedBits = ^{sa_sel_i, sa_dat_i};

`ifdef PRIO_INT_CTRL_SYNC_EN
   logic [INT_NUM-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= int_i;
         sync2_q <= sync1_q;
      end
   end

   assign inSync = sync2_q;
`else
   assign inSync = int_i;
`endif

   assign access = sa_stb_i && !ack_q;
   assign wrEn   = access && sa_we_i;
   assign wrData = sa_dat_i[INT_NUM-1:0];

   assign selMer = (sa_addr_i == ADDR_WIDTH'(ADDR_MER));
   assign selIer = (sa_addr_i == ADDR_WIDTH'(ADDR_IER));
   assign selIar = (sa_addr_i == ADDR_WIDTH'(ADDR_IAR));
   assign selIpr = (sa_addr_i == ADDR_WIDTH'(ADDR_IPR));
   assign selImr = (sa_addr_i == ADDR_WIDTH'(ADDR_IMR));
   assign selIvr = (sa_addr_i == ADDR_WIDTH'(ADDR_IVR));

   assign active = pending_q & ier_q;

   prio_enc #(.N(INT_NUM)) u_prio_enc (
      .req_i   (active),
      .idx_o   (encIdx),
      .valid_o (encValid)
   );

   // Register writes and the pending update; a new edge beats a same-cycle clear.
   always_comb begin
      mer_d = mer_q;
      ier_d = ier_q;
      imr_d = imr_q;
      if (wrEn && selMer) mer_d = sa_dat_i[1:0];
      if (wrEn && selIer) ier_d = wrData;
      if (wrEn && selImr) imr_d = wrData;
      imrChanged = imr_d ^ imr_q;
      edgeSet    = inSync & ~prevIn_q;
      swSet      = (wrEn && selIpr) ? wrData : '0;
      swClr      = (wrEn && selIar) ? wrData : '0;
      pending_d  = (imr_q & (edgeSet | swSet | (pending_q & ~swClr)))
                 | (~imr_q & inSync);
      pending_d  = pending_d & ~imrChanged;
      intOut_d   = (&mer_q) && (|active);
   end

   // Read data is captured once per access and held through the ack cycle.
   always_comb begin
      rdData_d = rdData_q;
      if (access) begin
         rdData_d = '0;
         if (selMer) begin
            rdData_d[1:0] = mer_q;
         end else if (selIer) begin
            rdData_d[INT_NUM-1:0] = ier_q;
         end else if (selIpr) begin
            rdData_d[INT_NUM-1:0] = pending_q;
         end else if (selImr) begin
            rdData_d[INT_NUM-1:0] = imr_q;
         end else if (selIvr) begin
            rdData_d[DATA_WIDTH-1] = encValid;
            rdData_d[VEC_W-1:0]    = encIdx;
         end
      end
   end

   // The edge history always tracks the current input, so a mode change never sees a stale edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         mer_q     <= '0;
         ier_q     <= '0;
         imr_q     <= '0;
         pending_q <= '0;
         prevIn_q  <= '0;
         rdData_q  <= '0;
         ack_q     <= 1'b0;
         intOut_q  <= 1'b0;
         vec_q     <= '0;
      end else begin
         mer_q     <= mer_d;
         ier_q     <= ier_d;
         imr_q     <= imr_d;
         pending_q <= pending_d;
         prevIn_q  <= inSync;
         rdData_q  <= rdData_d;
         ack_q     <= access;
         intOut_q  <= intOut_d;
         vec_q     <= encIdx;
      end
   end

   assign sa_dat_o  = rdData_q;
   assign sa_ack_o  = ack_q;
   assign int_o     = intOut_q;
   assign int_vec_o = vec_q;

endmodule

// File: tb/tb_prio_int_ctrl.sv
// Self-checking bench for prio_int_ctrl: directed vector table, reset and
// synchroniser-latency sequences, then randomised traffic against a model.
module tb_prio_int_ctrl;
   import int_ctrl_pkg::*;

`ifdef PRIO_INT_CTRL_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] datIn;
   logic [3:0]  sel;
   logic [2:0]  addr;
   logic        stb, we;
   logic [31:0] datOut;
   logic        ack;
   logic [7:0]  intIn;
   logic        intOut;
   logic [4:0]  vecOut;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [7:0]  intv;
      logic        chkData;
      logic [31:0] expData;
      logic        expInt;
      logic [4:0]  expVec;
   } vec_t;

   typedef struct packed {
      logic [1:0]  mer;
      logic [7:0]  ier, imr, pend, prev, dly0, dly1;
      logic        ack, intO;
      logic [4:0]  vec;
      logic [31:0] rd;
   } mstate_t;

   mstate_t mS;
   vec_t    vecs[$];

   always #5 clk = ~clk;

   prio_int_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .sa_dat_i  (datIn),
      .sa_sel_i  (sel),
      .sa_addr_i (addr),
      .sa_stb_i  (stb),
      .sa_we_i   (we),
      .sa_dat_o  (datOut),
      .sa_ack_o  (ack),
      .int_i     (intIn),
      .int_o     (intOut),
      .int_vec_o (vecOut)
   );

   // Lowest set bit isolated arithmetically, then converted to its index.
   function automatic logic [4:0] lowestIdx(input logic [7:0] a);
      logic [7:0] low;
      low = a & (~a + 8'd1);
      return 5'($clog2(low));
   endfunction

   function automatic mstate_t modelNext(input mstate_t s, input logic stbV, input logic weV,
                                         input logic [2:0] aV, input logic [31:0] dV,
                                         input logic [7:0] rawIn);
      mstate_t    n;
      logic [7:0] in, act, d;
      logic       latch, wr;
      n     = s;
      in    = (SYNC_LAT == 0) ? rawIn : s.dly1;
      n.dly1 = s.dly0;
      n.dly0 = rawIn;
      act   = s.pend & s.ier;
      latch = stbV && !s.ack;
      wr    = latch && weV;
      d     = dV[7:0];
      if (latch) begin
         case (aV)
            3'd0:    n.rd = {30'd0, s.mer};
            3'd1:    n.rd = {24'd0, s.ier};
            3'd3:    n.rd = {24'd0, s.pend};
            3'd4:    n.rd = {24'd0, s.imr};
            3'd5:    n.rd = {(act != 8'd0), 26'd0, lowestIdx(act)};
            default: n.rd = 32'd0;
         endcase
      end
      n.intO = (s.mer == 2'd3) && (act != 8'd0);
      n.vec  = lowestIdx(act);
      for (int i = 0; i < 8; i++) begin
         if (wr && aV == 3'd4 && d[i] != s.imr[i])
            n.pend[i] = 1'b0;
         else if (!s.imr[i])
            n.pend[i] = in[i];
         else
            n.pend[i] = (in[i] && !s.prev[i]) || (wr && aV == 3'd3 && d[i]) ||
                        (s.pend[i] && !(wr && aV == 3'd2 && d[i]));
      end
      if (wr && aV == 3'd0) n.mer = dV[1:0];
      if (wr && aV == 3'd1) n.ier = d;
      if (wr && aV == 3'd4) n.imr = d;
      n.prev = in;
      n.ack  = latch;
      return n;
   endfunction

   always @(posedge clk) begin
      if (reset) mS <= '0;
      else       mS <= modelNext(mS, stb, we, addr, datIn, intIn);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [31:0] d,
                                input logic [7:0] iv, input logic chkAck);
      we = w; addr = a; datIn = d; intIn = iv; stb = 1'b1;
      step();
      if (chkAck) checkOutput("ack_high", {31'd0, ack}, 32'd1);
      stb = 1'b0; we = 1'b0;
      step();
      if (chkAck) checkOutput("ack_low", {31'd0, ack}, 32'd0);
   endtask

   task automatic checkModel();
      checkOutput("rand_int_o", {31'd0, intOut}, {31'd0, mS.intO});
      checkOutput("rand_int_vec_o", {27'd0, vecOut}, {27'd0, mS.vec});
      checkOutput("rand_ack", {31'd0, ack}, {31'd0, mS.ack});
   endtask

   function automatic logic [7:0] randFlip();
      return 8'($urandom & $urandom & $urandom);
   endfunction

   task automatic randomAccess();
      logic [2:0]  a;
      logic [31:0] d;
      logic        w;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      if (a == ADDR_MER && $urandom_range(0, 3) != 0) d = 32'd3;
      addr = a; datIn = d; we = w; stb = 1'b1; intIn ^= randFlip();
      step();
      checkModel();
      stb = 1'b0; we = 1'b0; intIn ^= randFlip();
      step();
      checkModel();
      if (!w) checkOutput("rand_read", datOut, mS.rd);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; datIn = '0; sel = '0; addr = '0; stb = 1'b0; we = 1'b0; intIn = '0;
      step();
      step();
      reset = 1'b0;
      checkOutput("reset_int_o", {31'd0, intOut}, 32'd0);
      checkOutput("reset_int_vec_o", {27'd0, vecOut}, 32'd0);
      checkOutput("reset_ack", {31'd0, ack}, 32'd0);
      checkOutput("reset_dat_o", datOut, 32'd0);

`ifndef PRIO_INT_CTRL_SYNC_EN
      //             we    addr      data          int    chk   expData        int   vec
      vecs.push_back('{1'b1, ADDR_MER, 32'h3,        8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IER, 32'hFF,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IMR, 32'hFF,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h20, 1'b1, 32'h0,        1'b1, 5'd5});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h20,       1'b1, 5'd5});
      vecs.push_back('{1'b0, ADDR_IVR, 32'h0,        8'h00, 1'b1, 32'h80000005, 1'b1, 5'd5});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h20,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h44, 1'b1, 32'h0,        1'b1, 5'd2});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h04,       8'h00, 1'b0, 32'h0,        1'b1, 5'd6});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h40,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IMR, 32'h00,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h08, 1'b1, 32'h0,        1'b1, 5'd3});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h08, 1'b1, 32'h08,       1'b1, 5'd3});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h08,       8'h08, 1'b0, 32'h0,        1'b1, 5'd3});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h08, 1'b1, 32'h08,       1'b1, 5'd3});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h08,       1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IMR, 32'hFF,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h02, 1'b1, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h02,       1'b1, 5'd1});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h02,       8'h02, 1'b0, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h02,       1'b1, 5'd1});
      vecs.push_back('{1'b1, ADDR_MER, 32'h1,        8'h00, 1'b0, 32'h0,        1'b0, 5'd1});
      vecs.push_back('{1'b1, ADDR_MER, 32'h3,        8'h00, 1'b0, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_MER, 32'h0,        8'h00, 1'b1, 32'h3,        1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_IER, 32'h0,        8'h00, 1'b1, 32'hFF,       1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_IMR, 32'h0,        8'h00, 1'b1, 32'hFF,       1'b1, 5'd1});
      vecs.push_back('{1'b0, 3'd6,     32'h0,        8'h00, 1'b1, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b1, 3'd7,     32'hFF,       8'h00, 1'b0, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b0, 3'd7,     32'h0,        8'h00, 1'b1, 32'h0,        1'b1, 5'd1});
      vecs.push_back('{1'b0, ADDR_IVR, 32'h0,        8'h00, 1'b1, 32'h80000001, 1'b1, 5'd1});
      vecs.push_back('{1'b1, ADDR_IAR, 32'h02,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IVR, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IPR, 32'h10,       8'h00, 1'b0, 32'h0,        1'b1, 5'd4});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h10,       1'b1, 5'd4});
      vecs.push_back('{1'b1, ADDR_IMR, 32'hEF,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b1, ADDR_IPR, 32'h10,       8'h00, 1'b0, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IPR, 32'h0,        8'h00, 1'b1, 32'h0,        1'b0, 5'd0});
      vecs.push_back('{1'b0, ADDR_IMR, 32'h0,        8'h00, 1'b1, 32'hEF,       1'b0, 5'd0});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].intv, 1'b1);
         checkOutput($sformatf("vec%0d_int_o", i), {31'd0, intOut}, {31'd0, vecs[i].expInt});
         checkOutput($sformatf("vec%0d_int_vec_o", i), {27'd0, vecOut}, {27'd0, vecs[i].expVec});
         if (vecs[i].chkData)
            checkOutput($sformatf("vec%0d_dat_o", i), datOut, vecs[i].expData);
      end

      // Reset arriving mid-access must swallow the ack and clear everything.
      applyStimulus(1'b1, ADDR_IPR, 32'h01, 8'h00, 1'b0);
      checkOutput("pre_reset_int_o", {31'd0, intOut}, 32'd1);
      we = 1'b1; addr = ADDR_IER; datIn = 32'hAA; stb = 1'b1; reset = 1'b1;
      step();
      checkOutput("reset_abort_ack", {31'd0, ack}, 32'd0);
      reset = 1'b0; stb = 1'b0; we = 1'b0;
      step();
      checkOutput("post_reset_int_o", {31'd0, intOut}, 32'd0);
      checkOutput("post_reset_dat_o", datOut, 32'd0);
      for (int r = 0; r < 6; r++) begin
         applyStimulus(1'b0, 3'(r), 32'd0, 8'h00, 1'b1);
         checkOutput($sformatf("post_reset_reg%0d", r), datOut, 32'd0);
      end
`endif

      // Edge-to-int_o latency: pending after SYNC_LAT+1 edges, int_o one edge later.
      pulseReset();
      applyStimulus(1'b1, ADDR_MER, 32'h3, 8'h00, 1'b0);
      applyStimulus(1'b1, ADDR_IER, 32'hFF, 8'h00, 1'b0);
      applyStimulus(1'b1, ADDR_IMR, 32'hFF, 8'h00, 1'b0);
      intIn = 8'h01;
      for (int k = 1; k <= SYNC_LAT + 2; k++) begin
         step();
         checkOutput($sformatf("latency_int_o_c%0d", k), {31'd0, intOut},
                     (k == SYNC_LAT + 2) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b0, ADDR_IPR, 32'h0, 8'h01, 1'b0);
      checkOutput("latency_ipr", datOut, 32'h01);

      pulseReset();
      intIn = 8'h00;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            intIn ^= randFlip();
            step();
            checkModel();
         end else begin
            randomAccess();
         end
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/prio_int_ctrl.md
PRIO_INT_CTRL -- requirements
Module: prio_int_ctrl

Interface
REQ-001 SHALL have parameter INT_NUM, default 8, meaning number of interrupt channels (1..31).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning Wishbone data width (>= INT_NUM+1).
REQ-003 SHALL have parameter SEL_WIDTH, default 4, meaning byte-select width (accepted, unused).
REQ-004 SHALL have parameter ADDR_WIDTH, default 3, meaning word-address width.
REQ-005 SHALL have ports: clk input 1 system clock; reset input 1 synchronous active-high reset.
REQ-006 SHALL have ports: sa_dat_i input DATA_WIDTH; sa_sel_i input SEL_WIDTH; sa_addr_i input ADDR_WIDTH; sa_stb_i input 1; sa_we_i input 1.
REQ-007 SHALL have ports: sa_dat_o output DATA_WIDTH read data; sa_ack_o output 1 access acknowledge.
REQ-008 SHALL have ports: int_i input INT_NUM raw interrupt sources; int_o output 1 CPU interrupt request; int_vec_o output 5 index of the highest-priority active channel.
REQ-009 SHALL use reset reset, synchronous, active-high; clock clk.

Function
REQ-010 SHALL decode registers: 0 MER (rw, bits[1:0]); 1 IER (rw); 2 IAR (w1c of pending); 3 IPR (r; w1s = software trigger); 4 IMR (rw; 1 = edge, 0 = level per channel); 5 IVR (r: bit DATA_WIDTH-1 valid, bits[4:0] vector); 6-7 reserved (read 0, writes ignored).
REQ-011 SHALL assert sa_ack_o the cycle after sa_stb_i when sa_ack_o is low, and deassert it the next cycle; every access thus takes 2 cycles.
REQ-012 SHALL perform writes and latch read data only on the cycle sa_stb_i && !sa_ack_o; sa_dat_o holds the latched value, zero-extended.
REQ-013 Edge channel: pending SHALL set on a 0->1 transition of the (synchronised) input, detected against a one-cycle-delayed copy.
REQ-014 Level channel: pending SHALL equal the (synchronised) input each cycle; IAR and IPR writes SHALL have no effect on it.
REQ-015 Pending SHALL be captured regardless of IER; active = pending & IER.
REQ-016 On a simultaneous IAR clear and new edge on the same channel, pending SHALL remain set.
REQ-017 An IPR w1s SHALL set pending on edge channels only, effective next cycle.
REQ-018 Priority SHALL be fixed: lowest channel index wins; int_vec_o = index of the lowest set active bit, 0 when none.
REQ-019 int_o SHALL be registered: high one cycle after (MER == 2'b11) && |active, low one cycle after the condition clears.
REQ-020 IVR valid SHALL equal |active at read-latch time.
REQ-021 Writing IMR SHALL reset the delayed input copy of the changed channels to the current input (no spurious edge) and SHALL clear their pending bit.

Reset
REQ-022 On reset SHALL clear MER, IER, IMR, pending, edge history, synchroniser flops, read latch, sa_ack_o, int_o and int_vec_o to 0.
REQ-023 Reset asserted mid-access SHALL abort it; no ack is issued for that access.

Configuration
REQ-024 With macro PRIO_INT_CTRL_SYNC_EN defined, int_i SHALL pass through a 2-flop synchroniser per channel (+2 cycles to pending); undefined, int_i SHALL feed edge/level logic directly.

Structure
REQ-025 Register address constants (MER..IVR) and the vector width SHALL live in shared package int_ctrl_pkg.
REQ-026 The lowest-index priority encoder SHALL be a sub-module prio_enc (parameter N, outputs index and valid).

Verification (SYNC_EN undefined unless stated)
REQ-027 Write MER=3, IER=0xFF, IMR=0xFF; pulse int_i[5] one cycle -> IPR reads 0x20, int_o high, int_vec_o=5, IVR=0x80000005.
REQ-028 Edge pending on ch 2 and ch 6 -> int_vec_o=2; write IAR=0x04 -> int_vec_o=6; write IAR=0x40 -> int_o low the next cycle.
REQ-029 IMR=0, hold int_i[3]=1 -> IPR=0x08; write IAR=0x08 -> IPR still 0x08; drop int_i[3] -> IPR=0 next cycle.
REQ-030 IAR=0x02 write coincides with a new ch 1 edge -> IPR bit1 stays 1.
REQ-031 MER=1 with pending active -> int_o stays 0; MER=3 -> int_o rises next cycle; reset asserted -> all registers and outputs read 0.
REQ-032 With PRIO_INT_CTRL_SYNC_EN defined, ch 0 edge -> IPR bit0 sets 3 cycles after int_i rises (2 sync + 1 edge detect).
